// File: rtl/layer_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding and timestep index width.
package layer_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LAUNCH     = 3'd1;
    localparam logic [2:0] ST_WAIT_GATES = 3'd2;
    localparam logic [2:0] ST_ELEM       = 3'd3;
    localparam logic [2:0] ST_WAIT_ELEM  = 3'd4;
    localparam logic [2:0] ST_COMMIT     = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    typedef enum logic [2:0] {
        StIdle      = ST_IDLE,
        StLaunch    = ST_LAUNCH,
        StWaitGates = ST_WAIT_GATES,
        StElem      = ST_ELEM,
        StWaitElem  = ST_WAIT_ELEM,
        StCommit    = ST_COMMIT,
        StDone      = ST_DONE
    } state_e;

    // A single-step sequence still needs a one-bit index.
    function automatic int unsigned ts_width(input int unsigned seq_len);
        return (seq_len > 1) ? $clog2(seq_len) : 1;
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Wait-state watchdog for layer_sched; only built with LAYER_SCHED_TIMEOUT_EN defined.
`ifdef LAYER_SCHED_TIMEOUT_EN
module sched_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    // Dropping i_active between the two wait states restarts the count on entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_active || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_active && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/layer_sched.sv
// Per-timestep sequencer: launch gates, collect ready pulses, run element unit, commit h.
// Optional watchdog and o_error port enabled by defining LAYER_SCHED_TIMEOUT_EN.
module layer_sched
    import layer_pkg::*;
#(
    parameter int unsigned NUM_GATES   = 4,
    parameter int unsigned SEQ_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [NUM_GATES-1:0]          i_gate_ready,
    input  logic                          i_elem_done,
    output logic                          o_begin_calc,
    output logic                          o_begin_elem,
    output logic                          o_h_latch,
    output logic [ts_width(SEQ_LEN)-1:0]  o_time_step,
    output logic                          o_busy,
    output logic                          o_seq_done
`ifdef LAYER_SCHED_TIMEOUT_EN
    ,
    output logic                          o_error
`endif
);

    localparam int unsigned          TSW       = ts_width(SEQ_LEN);
    localparam logic [TSW-1:0]       LAST_TS   = TSW'(SEQ_LEN - 1);
    localparam logic [NUM_GATES-1:0] ALL_GATES = '1;

    state_e               r_state, w_state_next;
    logic [TSW-1:0]       r_ts, w_ts_next;
    logic [NUM_GATES-1:0] r_mask, w_mask_next;
    logic                 w_expire;
    logic                 w_waiting;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_ts    <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ts    <= w_ts_next;
            r_mask  <= w_mask_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ts_next    = r_ts;
        w_mask_next  = r_mask;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StLaunch;
                    w_ts_next    = '0;
                end
            end
            StLaunch: begin
                w_mask_next  = '0;
                w_state_next = StWaitGates;
            end
            StWaitGates: begin
                w_mask_next = r_mask | i_gate_ready;
                if ((r_mask | i_gate_ready) == ALL_GATES) begin
                    w_state_next = StElem;
                end else if (w_expire) begin
                    w_state_next = StIdle;
                end
            end
            StElem: w_state_next = StWaitElem;
            StWaitElem: begin
                if (i_elem_done) begin
                    w_state_next = StCommit;
                end else if (w_expire) begin
                    w_state_next = StIdle;
                end
            end
            StCommit: begin
                if (r_ts == LAST_TS) begin
                    w_state_next = StDone;
                end else begin
                    w_ts_next    = r_ts + 1'b1;
                    w_state_next = StLaunch;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_waiting    = (r_state == StWaitGates) || (r_state == StWaitElem);
    assign o_begin_calc = (r_state == StLaunch);
    assign o_begin_elem = (r_state == StElem);
    assign o_h_latch    = (r_state == StCommit);
    assign o_seq_done   = (r_state == StDone);
    assign o_busy       = (r_state != StIdle);
    assign o_time_step  = r_ts;

`ifdef LAYER_SCHED_TIMEOUT_EN
    logic r_error;

    sched_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_active (w_waiting),
        .o_expire (w_expire)
    );

    // Only a real abort sets the flag; a wait that completes on its last cycle does not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_error <= 1'b0;
        end else if ((r_state == StIdle) && i_start) begin
            r_error <= 1'b0;
        end else if (w_expire && (w_state_next == StIdle)) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign w_unused_timeout = w_waiting ^ (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_layer_sched.sv
// Bench for layer_sched: randomized gate/element delays checked against a cycle-schedule model.
module tb_layer_sched;
    import layer_pkg::*;

    localparam int NG  = 4;
    localparam int SL  = 3;
    localparam int TSW = ts_width(SL);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [NG-1:0]  gate_ready = '0;
    logic           elem_done = 1'b0;
    logic           begin_calc, begin_elem, h_latch, busy, seq_done;
    logic [TSW-1:0] time_step;

    always #5 clk = ~clk;

`ifdef LAYER_SCHED_TIMEOUT_EN
    logic           error;
    logic           calc_to, elem_to, latch_to, busy_to, done_to, error_to;
    logic [TSW-1:0] ts_to;

    layer_sched #(.NUM_GATES(NG), .SEQ_LEN(SL), .TIMEOUT_CYC(1024)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_gate_ready(gate_ready),
        .i_elem_done(elem_done), .o_begin_calc(begin_calc), .o_begin_elem(begin_elem),
        .o_h_latch(h_latch), .o_time_step(time_step), .o_busy(busy), .o_seq_done(seq_done),
        .o_error(error)
    );

    layer_sched #(.NUM_GATES(NG), .SEQ_LEN(SL), .TIMEOUT_CYC(8)) u_dut_to (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_gate_ready(gate_ready),
        .i_elem_done(elem_done), .o_begin_calc(calc_to), .o_begin_elem(elem_to),
        .o_h_latch(latch_to), .o_time_step(ts_to), .o_busy(busy_to), .o_seq_done(done_to),
        .o_error(error_to)
    );
`else
    layer_sched #(.NUM_GATES(NG), .SEQ_LEN(SL)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_gate_ready(gate_ready),
        .i_elem_done(elem_done), .o_begin_calc(begin_calc), .o_begin_elem(begin_elem),
        .o_h_latch(h_latch), .o_time_step(time_step), .o_busy(busy), .o_seq_done(seq_done)
    );
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // Scenario description: gate delays and element delay per timestep, relative to events.
    int gd[SL][NG];
    int ek[SL];
    bit stray;
    bit hold;

    // Model: expected cycle of each event, cycle 0 being the one where start is first driven.
    int launch_c[SL];
    int elem_c[SL];
    int latch_c[SL];
    int done_c;
    int idle_c;

    task automatic build_model();
        int maxd;
        launch_c[0] = 1;
        for (int t = 0; t < SL; t++) begin
            maxd = 0;
            for (int i = 0; i < NG; i++) if (gd[t][i] > maxd) maxd = gd[t][i];
            elem_c[t]  = launch_c[t] + maxd + 1;
            latch_c[t] = elem_c[t] + ek[t] + 1;
            if (t < SL - 1) launch_c[t + 1] = latch_c[t] + 1;
        end
        done_c = latch_c[SL - 1] + 1;
        idle_c = done_c + 1;
    endtask

    task automatic randomize_scenario();
        for (int t = 0; t < SL; t++) begin
            for (int i = 0; i < NG; i++) gd[t][i] = int'($urandom_range(1, 6));
            ek[t] = int'($urandom_range(1, 4));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        gate_ready = '0;
        elem_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives one scenario cycle by cycle and checks every output against the model schedule.
    task automatic run_schedule(input string name, input int stop_c);
        int last_c, relaunch_c, exp_ts;
        bit exp_calc, exp_elem, exp_latch, exp_done, exp_busy, e;
        logic [NG-1:0] g;
        build_model();
        relaunch_c = hold ? idle_c + 1 : -1;
        last_c = (stop_c >= 0) ? stop_c : (hold ? relaunch_c + 1 : idle_c + 1);
        for (int c = 0; c <= last_c; c++) begin
            g = '0;
            e = 1'b0;
            for (int t = 0; t < SL; t++) begin
                for (int i = 0; i < NG; i++) if (c == launch_c[t] + gd[t][i]) g[i] = 1'b1;
                if (c == elem_c[t] + ek[t]) e = 1'b1;
                if (stray && (c == 0 || c == launch_c[t])) begin
                    g = '1;
                    e = 1'b1;
                end
                if (stray && (c == elem_c[t] - 1 || c == elem_c[t] || c == latch_c[t])) e = 1'b1;
            end
            if (stray && c == done_c) e = 1'b1;
            start = (c == 0) || hold;
            gate_ready = g;
            elem_done = e;
            @(negedge clk);
            exp_calc = (c == relaunch_c);
            exp_elem = 1'b0;
            exp_latch = 1'b0;
            exp_ts = 0;
            for (int t = 0; t < SL; t++) begin
                if (c == launch_c[t]) exp_calc = 1'b1;
                if (c == elem_c[t]) exp_elem = 1'b1;
                if (c == latch_c[t]) exp_latch = 1'b1;
                if (c >= launch_c[t] && c <= latch_c[t]) exp_ts = t;
            end
            if (c >= done_c) exp_ts = SL - 1;
            if (hold && c >= relaunch_c) exp_ts = 0;
            exp_done = (c == done_c);
            exp_busy = (c >= 1 && c <= done_c) || (hold && c >= relaunch_c);
            total_cnt += 6;
            if (begin_calc !== exp_calc)
                $display("FAIL %s cyc=%0d begin_calc got %b want %b", name, c, begin_calc, exp_calc);
            else pass_cnt++;
            if (begin_elem !== exp_elem)
                $display("FAIL %s cyc=%0d begin_elem got %b want %b", name, c, begin_elem, exp_elem);
            else pass_cnt++;
            if (h_latch !== exp_latch)
                $display("FAIL %s cyc=%0d h_latch got %b want %b", name, c, h_latch, exp_latch);
            else pass_cnt++;
            if (seq_done !== exp_done)
                $display("FAIL %s cyc=%0d seq_done got %b want %b", name, c, seq_done, exp_done);
            else pass_cnt++;
            if (busy !== exp_busy)
                $display("FAIL %s cyc=%0d busy got %b want %b", name, c, busy, exp_busy);
            else pass_cnt++;
            if (time_step !== TSW'(exp_ts))
                $display("FAIL %s cyc=%0d time_step got %0d want %0d", name, c, time_step, exp_ts);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        gate_ready = '0;
        elem_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total_cnt += 4;
        if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else pass_cnt++;
        if (time_step !== '0) $display("FAIL reset time_step got %0d want 0", time_step);
        else pass_cnt++;
        if ({begin_calc, begin_elem, h_latch} !== 3'b000)
            $display("FAIL reset pulses got %b want 000", {begin_calc, begin_elem, h_latch});
        else pass_cnt++;
        if (seq_done !== 1'b0) $display("FAIL reset seq_done got %b want 0", seq_done);
        else pass_cnt++;
`ifdef LAYER_SCHED_TIMEOUT_EN
        total_cnt++;
        if (error !== 1'b0) $display("FAIL reset error got %b want 0", error); else pass_cnt++;
`endif
        do_reset();
    endtask

    task automatic test_sync_gates();
        do_reset();
        stray = 1'b0;
        hold = 1'b0;
        for (int t = 0; t < SL; t++) begin
            for (int i = 0; i < NG; i++) gd[t][i] = 2;
            ek[t] = 2;
        end
        run_schedule("sync_gates", -1);
    endtask

    task automatic test_staggered();
        do_reset();
        stray = 1'b0;
        hold = 1'b0;
        randomize_scenario();
        gd[0] = '{3, 8, 6, 11};
        run_schedule("staggered", -1);
    endtask

    task automatic test_stray_pulses();
        do_reset();
        stray = 1'b1;
        hold = 1'b0;
        randomize_scenario();
        run_schedule("stray_pulses", -1);
        stray = 1'b0;
    endtask

    task automatic test_random();
        stray = 1'b0;
        hold = 1'b0;
        for (int n = 0; n < 4; n++) begin
            do_reset();
            randomize_scenario();
            run_schedule("random", -1);
        end
    endtask

    task automatic test_start_held();
        do_reset();
        stray = 1'b0;
        hold = 1'b1;
        randomize_scenario();
        run_schedule("start_held", -1);
        hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        stray = 1'b0;
        hold = 1'b0;
        randomize_scenario();
        ek[1] = 5;
        build_model();
        run_schedule("reset_mid", elem_c[1] + 2);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt += 3;
        if (busy !== 1'b0) $display("FAIL reset_mid busy got %b want 0", busy); else pass_cnt++;
        if (time_step !== '0) $display("FAIL reset_mid time_step got %0d want 0", time_step);
        else pass_cnt++;
        if ({begin_calc, begin_elem, h_latch, seq_done} !== 4'b0000)
            $display("FAIL reset_mid pulses got %b want 0000",
                     {begin_calc, begin_elem, h_latch, seq_done});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            elem_done = 1'b1;
            gate_ready = NG'($urandom);
            @(negedge clk);
            total_cnt += 2;
            if ({h_latch, seq_done} !== 2'b00)
                $display("FAIL reset_mid_after cyc=%0d latch/done got %b want 00", c,
                         {h_latch, seq_done});
            else pass_cnt++;
            if ({busy, time_step} !== '0)
                $display("FAIL reset_mid_after cyc=%0d busy/ts got %b want 0", c,
                         {busy, time_step});
            else pass_cnt++;
        end
        elem_done = 1'b0;
        gate_ready = '0;
    endtask

`ifdef LAYER_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit exp_busy, exp_err;
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            start = (c == 0) || (c == 11);
            gate_ready = (c == 3) ? 4'b0111 : 4'b0000;
            @(negedge clk);
            exp_busy = (c >= 1 && c <= 9) || (c >= 12);
            exp_err = (c == 10) || (c == 11);
            total_cnt += 3;
            if (busy_to !== exp_busy)
                $display("FAIL timeout cyc=%0d busy got %b want %b", c, busy_to, exp_busy);
            else pass_cnt++;
            if (error_to !== exp_err)
                $display("FAIL timeout cyc=%0d error got %b want %b", c, error_to, exp_err);
            else pass_cnt++;
            if ({latch_to, done_to} !== 2'b00)
                $display("FAIL timeout cyc=%0d latch/done got %b want 00", c,
                         {latch_to, done_to});
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        gate_ready = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_sync_gates();
        test_staggered();
        test_stray_pulses();
        test_random();
        test_start_held();
        test_reset_mid();
`ifdef LAYER_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 SHALL have parameter NUM_GATES, default 4, number of gate instances sequenced in parallel.
REQ-002 SHALL have parameter SEQ_LEN, default 16, timesteps per sequence (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles per wait state.
REQ-004 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  level; begins a sequence when sampled high in IDLE.
REQ-007 SHALL have port gateReady  in  NUM_GATES  per-gate dataReady_gate one-cycle pulses.
REQ-008 SHALL have port elemDone  in  1  one-cycle pulse from the element-wise (cell/hidden) unit.
REQ-009 SHALL have port beginCalc  out  1  one-cycle pulse broadcast to all gates.
REQ-010 SHALL have port beginElem  out  1  one-cycle pulse starting the element-wise unit.
REQ-011 SHALL have port hLatch  out  1  one-cycle pulse loading new h into the prevLayerOut register.
REQ-012 SHALL have port timeStep  out  clog2(SEQ_LEN) (min 1)  current timestep index, selects input vector.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port seqDone  out  1  one-cycle pulse after final commit.
REQ-015 SHALL have port error  out  1  sticky watchdog flag (present only with LAYER_SCHED_TIMEOUT_EN).

Function
REQ-016 SHALL implement Moore FSM: IDLE, LAUNCH, WAIT_GATES, ELEM, WAIT_ELEM, COMMIT, DONE; outputs decoded from registered state.
REQ-017 SHALL transition IDLE->LAUNCH when start=1; timeStep cleared to 0 on that edge.
REQ-018 SHALL assert beginCalc only in LAUNCH (exactly one cycle); LAUNCH->WAIT_GATES unconditionally.
REQ-019 SHALL hold a NUM_GATES-bit sticky mask, cleared in LAUNCH, OR-ing gateReady only while in WAIT_GATES; pulses in other states ignored.
REQ-020 SHALL leave WAIT_GATES for ELEM on the cycle mask|gateReady is all-ones (simultaneous and staggered arrivals equivalent; earliest exit one cycle after the last pulse).
REQ-021 SHALL assert beginElem only in ELEM (one cycle); ELEM->WAIT_ELEM.
REQ-022 SHALL go WAIT_ELEM->COMMIT on elemDone=1; elemDone outside WAIT_ELEM ignored.
REQ-023 SHALL assert hLatch only in COMMIT; if timeStep==SEQ_LEN-1 go DONE, else increment timeStep and go LAUNCH.
REQ-024 SHALL hold timeStep at SEQ_LEN-1 in DONE/IDLE (no wrap to 0) until next accepted start.
REQ-025 SHALL assert seqDone only in DONE (one cycle); DONE->IDLE.
REQ-026 SHALL ignore start while busy=1; start held high through DONE begins a new sequence from IDLE next cycle.
REQ-027 SHALL give minimum per-timestep latency of 5 cycles (LAUNCH..COMMIT) plus gate and element wait times.

Reset
REQ-028 SHALL on reset=0, immediately and regardless of state: state=IDLE, timeStep=0, mask=0, watchdog=0, error=0, all pulse outputs 0, busy=0.
REQ-029 SHALL on reset mid-sequence discard progress; no seqDone is produced for the aborted sequence.

Configuration
REQ-030 SHALL, with LAYER_SCHED_TIMEOUT_EN defined, count cycles in WAIT_GATES/WAIT_ELEM (cleared on entry); at TIMEOUT_CYC set error and go IDLE without hLatch/seqDone.
REQ-031 SHALL clear error on the next accepted start.
REQ-032 SHALL, without LAYER_SCHED_TIMEOUT_EN, omit counter and error port; wait states wait indefinitely.

Structure
REQ-033 SHALL place state encoding (3-bit localparams) and the timestep width function in shared package layer_pkg.
REQ-034 SHALL be a single module; optional sub-module sched_watchdog for the timeout counter.

Verification
REQ-035 SHALL test SEQ_LEN=3, NUM_GATES=4, all gateReady same cycle, elemDone 2 cycles after beginElem -> 3 beginCalc, 3 hLatch, timeStep 0,1,2, one seqDone.
REQ-036 SHALL test staggered gateReady (bits 0,2,1,3 on cycles 4,7,9,12) -> beginElem exactly on cycle 13.
REQ-037 SHALL test gateReady/elemDone pulsed in IDLE and LAUNCH -> ignored, FSM still waits for fresh pulses.
REQ-038 SHALL test start held high for whole run -> no restart while busy; new LAUNCH the cycle after IDLE following seqDone.
REQ-039 SHALL test reset=0 during WAIT_ELEM at timeStep 1 -> immediate IDLE, timeStep=0, no hLatch/seqDone.
REQ-040 SHALL test (macro on, TIMEOUT_CYC=8) gate 3 never responds -> error=1 after 8 WAIT_GATES cycles, IDLE, cleared by next start.
